ctrl_encoder: RTL and testbench

- Inverse of the main control decoder: takes an 8-bit datapath control bundle and recovers the 2-bit opcode {x1,x2} that produces it.
- Sits on the trace/verification path after the control stage. Legal bundles are encoded and buffered in a small FIFO for a downstream consumer.
- Illegal bundles are dropped, counted and flagged.
- Per-class saturating counters give an instruction-mix profile.

---
 rtl/ctrl_encoder.sv | 134 +++++++++++++
 tb/tb_ctrl_encoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_encoder.sv
// Control-bundle encoder: recovers the {x1,x2} opcode from a datapath control
// bundle, queues legal opcodes in a small FIFO and profiles the instruction mix.
module ctrl_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             reg_dst,
  input  logic             reg_write,
  input  logic             alu_src,
  input  logic             branch,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_to_reg,
  input  logic             alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             x1,
  output logic             x2,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] cnt_r,
  output logic [CNT_W-1:0] cnt_ld,
  output logic [CNT_W-1:0] cnt_st,
  output logic [CNT_W-1:0] cnt_br,
  output logic [CNT_W-1:0] cnt_bad
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int NCNT = 5;

  logic [1:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       last_q, last_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q [NCNT];
  logic [NCNT-1:0]  cnt_inc;

  logic is_r, is_ld, is_st, is_br, legal;
  logic full, empty, accept, push, pop;
  logic [1:0] op;

  // Exact-match decode; store/branch ignore reg_dst and mem_to_reg.
  always_comb begin
    is_r  = reg_dst & reg_write & ~alu_src & ~branch & ~mem_read & ~mem_write
            & ~mem_to_reg & alu_op;
    is_ld = ~reg_dst & reg_write & alu_src & ~branch & mem_read & ~mem_write
            & mem_to_reg & ~alu_op;
    is_st = ~reg_write & alu_src & ~branch & ~mem_read & mem_write & ~alu_op;
    is_br = ~reg_write & ~alu_src & branch & ~mem_read & ~mem_write & ~alu_op;
    legal = is_r | is_ld | is_st | is_br;
    op    = {is_st | is_br, is_ld | is_br};
  end

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = ~full;
  assign accept   = in_valid & in_ready;
  assign push     = accept & legal;
  assign pop      = ~empty & out_ready;

  assign cnt_inc = {accept & ~legal, accept & is_br, accept & is_st,
                    accept & is_ld, accept & is_r};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    err_d    = err_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Set has priority over clear when both land on the same edge.
    if (err_clr) err_d = 1'b0;
    if (accept && !legal) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= op;
  end

  generate
    for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
          cnt_q[gi] <= cnt_q[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign out_valid = ~empty;
  assign {x1, x2}  = empty ? last_q : mem_q[rd_ptr_q];
  assign err       = err_q;
  assign cnt_r     = cnt_q[0];
  assign cnt_ld    = cnt_q[1];
  assign cnt_st    = cnt_q[2];
  assign cnt_br    = cnt_q[3];
  assign cnt_bad   = cnt_q[4];

endmodule

// File: tb/tb_ctrl_encoder.sv
// Directed bench for ctrl_encoder: directed checks plus a queue model of the
// FIFO that verifies occupancy flags and popped opcodes every cycle.
module tb_ctrl_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  localparam logic [7:0] B_R   = 8'b1100_0001;
  localparam logic [7:0] B_LD  = 8'b0110_1010;
  localparam logic [7:0] B_ST  = 8'b1010_0100;
  localparam logic [7:0] B_BR  = 8'b0001_0010;
  localparam logic [7:0] B_BAD = 8'b1111_1111;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, x1, x2, err, err_clr;
  logic reg_dst, reg_write, alu_src, branch, mem_read, mem_write, mem_to_reg, alu_op;
  logic [CNT_W-1:0] cnt_r, cnt_ld, cnt_st, cnt_br, cnt_bad;

  int total = 0;
  int passed = 0;
  int pops = 0;
  bit chk_en = 0;
  bit cur_legal = 0;
  logic [1:0] cur_op = 2'b00;
  logic [1:0] mq[$];
  logic [7:0] bvec [4];
  logic [1:0] ovec [4];

  always #5 clk = ~clk;

  ctrl_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src), .branch(branch),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready), .x1(x1), .x2(x2),
    .err(err), .err_clr(err_clr),
    .cnt_r(cnt_r), .cnt_ld(cnt_ld), .cnt_st(cnt_st), .cnt_br(cnt_br), .cnt_bad(cnt_bad)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input bit v, input logic [7:0] b, input bit lg, input logic [1:0] o);
    in_valid = v;
    {reg_dst, reg_write, alu_src, branch, mem_read, mem_write, mem_to_reg, alu_op} = b;
    cur_legal = lg;
    cur_op = o;
  endtask

  // One clock: flags checked before the edge, popped head checked against the model.
  task automatic tick();
    bit acc, pop;
    logic [1:0] head;
    if (chk_en && !rst) begin
      check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    end
    acc  = in_valid && (mq.size() < DEPTH) && cur_legal;
    pop  = (mq.size() != 0) && out_ready;
    head = {x1, x2};
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
    end else begin
      if (pop) begin
        check("pop_head", 32'(head), 32'(mq[0]));
        $display("pop opcode=%b", head);
        void'(mq.pop_front());
        pops++;
      end
      if (acc) mq.push_back(cur_op);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bvec = '{B_R, B_LD, B_ST, B_BR};
    ovec = '{2'b00, 2'b01, 2'b10, 2'b11};
    rst = 1'b1; out_ready = 1'b0; err_clr = 1'b0;
    drive(0, 8'h00, 0, 2'b00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_x", 32'({x1, x2}), 0);
    check("rst_err", 32'(err), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_cnt_r", 32'(cnt_r), 0);
    check("rst_cnt_bad", 32'(cnt_bad), 0);

    // One of each class, streamed with out_ready=1
    out_ready = 1'b1;
    drive(1, B_R, 1, 2'b00);  tick(); check("seq_r", 32'({out_valid, x1, x2}), 32'b100);
    drive(1, B_LD, 1, 2'b01); tick(); check("seq_ld", 32'({out_valid, x1, x2}), 32'b101);
    drive(1, B_ST, 1, 2'b10); tick(); check("seq_st", 32'({out_valid, x1, x2}), 32'b110);
    drive(1, B_BR, 1, 2'b11); tick(); check("seq_br", 32'({out_valid, x1, x2}), 32'b111);
    drive(0, 8'h00, 0, 2'b00); tick();
    check("idle_hold_x", 32'({out_valid, x1, x2}), 32'b011);
    check("cnt_r_1", 32'(cnt_r), 1);
    check("cnt_ld_1", 32'(cnt_ld), 1);
    check("cnt_st_1", 32'(cnt_st), 1);
    check("cnt_br_1", 32'(cnt_br), 1);
    check("err_0", 32'(err), 0);

    // Illegal bundle between two R-type bundles
    drive(1, B_R, 1, 2'b00);   tick(); check("ill_r1", 32'({out_valid, x1, x2}), 32'b100);
    drive(1, B_BAD, 0, 2'b00); tick();
    check("ill_gap", 32'(out_valid), 0);
    check("ill_err", 32'(err), 1);
    check("ill_cnt_bad", 32'(cnt_bad), 1);
    drive(1, B_R, 1, 2'b00);   tick(); check("ill_r2", 32'({out_valid, x1, x2}), 32'b100);
    drive(0, 8'h00, 0, 2'b00); tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_cleared", 32'(err), 0);

    // Illegal accept and err_clr on the same edge: set wins
    drive(1, B_BAD, 0, 2'b00); err_clr = 1'b1; tick();
    err_clr = 1'b0; drive(0, 8'h00, 0, 2'b00);
    check("set_wins_err", 32'(err), 1);
    check("set_wins_cnt_bad", 32'(cnt_bad), 2);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_cleared2", 32'(err), 0);

    // Backpressure: five loads into a 4-deep FIFO
    out_ready = 1'b0;
    drive(1, B_LD, 1, 2'b01);
    repeat (4) tick();
    check("full_in_ready", 32'(in_ready), 0);
    tick();
    check("held_in_ready", 32'(in_ready), 0);
    check("held_head", 32'({out_valid, x1, x2}), 32'b101);
    pops = 0;
    out_ready = 1'b1;
    tick();
    check("drain_in_ready", 32'(in_ready), 1);
    tick();
    drive(0, 8'h00, 0, 2'b00);
    repeat (4) tick();
    check("bp_pops", 32'(pops), 5);
    check("bp_empty", 32'(out_valid), 0);
    check("cnt_ld_6", 32'(cnt_ld), 6);
    check("cnt_r_3", 32'(cnt_r), 3);

    // Full FIFO with continuous input and output
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, bvec[i], 1, ovec[i]);
      tick();
    end
    check("fill_full", 32'(in_ready), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, bvec[(i + 1) % 4], 1, ovec[(i + 1) % 4]);
      tick();
      check("stream_occ", 32'(mq.size() <= DEPTH), 1);
    end
    drive(0, 8'h00, 0, 2'b00);
    repeat (5) tick();
    check("stream_empty", 32'(out_valid), 0);

    // Branch counter saturation (CNT_W=4)
    drive(1, B_BR, 1, 2'b11);
    repeat (20) tick();
    drive(0, 8'h00, 0, 2'b00);
    tick(); tick();
    check("cnt_br_sat", 32'(cnt_br), 15);
    check("cnt_bad_keep", 32'(cnt_bad), 2);

    // Reset mid-operation with 3 queued entries and err set
    out_ready = 1'b0;
    drive(1, B_R, 1, 2'b00);
    repeat (3) tick();
    drive(1, B_BAD, 0, 2'b00); tick();
    drive(0, 8'h00, 0, 2'b00);
    check("pre_rst_err", 32'(err), 1);
    check("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_x", 32'({x1, x2}), 0);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    check("mid_rst_cnts", 32'({cnt_r, cnt_ld, cnt_st, cnt_br, cnt_bad}), 0);
    out_ready = 1'b1;
    repeat (2) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
